// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: channel state encoding and counter width helper for clk_gate_ctrl
package clk_gate_pkg;
  typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_RUN, CG_GATED} cg_state_e;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/icg_cell.sv
// icg_cell: latch-based glitch-free clock gate, enable captured while clk is low
module icg_cell (
  input  logic clk,
  input  logic en,
  output logic gclk
);
  logic en_l;
  always_latch
    if (!clk) en_l <= en;
  assign gclk = clk & en_l;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: N-channel clock gate controller with enable, idle auto-gating and timed wake-up
// Optional gated-cycle statistics when CLK_GATE_STATS_EN is defined.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   ch_busy,
  output logic [N_CH-1:0]   g_clk,
  output logic [N_CH-1:0]   ch_on,
  output logic [N_CH-1:0]   ch_rdy
`ifdef CLK_GATE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [N_CH*CNT_W-1:0] gated_cnt
`endif
);
  localparam int IW = cnt_w(IDLE_CYC);
  localparam int WW = cnt_w(WAKE_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [WW-1:0] WAKE_INIT = WW'(WAKE_CYC - 1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cg_state_e state, state_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [WW-1:0] wake_cnt, wake_n;
    logic on_q;
    always_comb begin
      state_n = state;
      idle_n  = idle_cnt;
      wake_n  = wake_cnt;
      unique case (state)
        CG_OFF:
          if (ch_en[i]) begin
            state_n = CG_WAKE;
            wake_n  = WAKE_INIT;
          end
        CG_WAKE:
          if (!ch_en[i]) state_n = CG_OFF;
          else if (wake_cnt == '0) begin
            state_n = CG_RUN;
            idle_n  = '0;
          end else wake_n = wake_cnt - 1'b1;
        CG_RUN:
          if (!ch_en[i]) state_n = CG_OFF;
          else if (ch_busy[i]) idle_n = '0;
          else if (IDLE_CYC != 0 && idle_cnt == IDLE_LAST) state_n = CG_GATED;
          else if (idle_cnt != '1) idle_n = idle_cnt + 1'b1;
        CG_GATED:
          if (!ch_en[i]) state_n = CG_OFF;
          else if (ch_busy[i]) begin
            state_n = CG_WAKE;
            wake_n  = WAKE_INIT;
          end
        default: state_n = CG_OFF;
      endcase
    end
    always_ff @(posedge clk)
      if (rst) begin
        state    <= CG_OFF;
        on_q     <= 1'b0;
        idle_cnt <= '0;
        wake_cnt <= '0;
      end else begin
        state    <= state_n;
        on_q     <= (state_n == CG_WAKE) || (state_n == CG_RUN);
        idle_cnt <= idle_n;
        wake_cnt <= wake_n;
      end
    assign ch_on[i]  = on_q;
    assign ch_rdy[i] = (state == CG_RUN);
    icg_cell u_icg (.clk(clk), .en(on_q), .gclk(g_clk[i]));
`ifdef CLK_GATE_STATS_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
      if (rst || stats_clr) cnt <= '0;
      else if (!on_q && cnt != '1) cnt <= cnt + 1'b1;
    assign gated_cnt[i*CNT_W +: CNT_W] = cnt;
`endif
  end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed and randomized check of clk_gate_ctrl against a behavioural channel model
module tb_clk_gate_ctrl;
  localparam int N = 4, IDLE = 16, WAKE = 2, CW = 16;
  logic clk = 0, rst = 1, stats_clr = 0;
  logic [N-1:0] ch_en = '1, ch_busy = '0;
  logic [N-1:0] g_clk, ch_on, ch_rdy;
  logic [N*CW-1:0] gated_cnt;
  int n_tests = 0, n_fail = 0;

  clk_gate_ctrl #(.N_CH(N), .IDLE_CYC(IDLE), .WAKE_CYC(WAKE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_busy(ch_busy),
    .g_clk(g_clk), .ch_on(ch_on), .ch_rdy(ch_rdy)
`ifdef CLK_GATE_STATS_EN
    , .stats_clr(stats_clr), .gated_cnt(gated_cnt)
`endif
  );
`ifndef CLK_GATE_STATS_EN
  assign gated_cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a channel is clocked (m_on) or not; a clocked channel is either
  // counting down its wake time (m_wl >= 0) or ready; an unclocked one is either
  // switched off or parked by the idle timeout (m_gated).
  bit m_on[N], m_gated[N], mvalid = 0;
  int m_wl[N], m_idle[N], m_cnt[N];

  function automatic logic [N-1:0] m_on_vec();
    for (int c = 0; c < N; c++) m_on_vec[c] = m_on[c];
  endfunction
  function automatic logic [N-1:0] m_rdy_vec();
    for (int c = 0; c < N; c++) m_rdy_vec[c] = m_on[c] && m_wl[c] < 0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] pre_on;
    bit pv;
    pre_on = m_on_vec();
    pv = mvalid;
    for (int c = 0; c < N; c++) begin
      if (rst || stats_clr) m_cnt[c] = 0;
      else if (!m_on[c] && m_cnt[c] < 65535) m_cnt[c]++;
      if (rst || !ch_en[c]) begin
        m_on[c] = 0; m_gated[c] = 0; m_wl[c] = -1;
        if (rst) m_idle[c] = 0;
      end else if (!m_on[c]) begin
        if (!m_gated[c] || ch_busy[c]) begin
          m_on[c] = 1; m_gated[c] = 0; m_wl[c] = WAKE - 1;
        end
      end else if (m_wl[c] >= 0) begin
        m_wl[c]--;
        if (m_wl[c] < 0) m_idle[c] = 0;
      end else if (ch_busy[c]) m_idle[c] = 0;
      else if (++m_idle[c] == IDLE && IDLE != 0) begin
        m_on[c] = 0; m_gated[c] = 1;
      end
    end
    if (rst) mvalid = 1;
    #1;
    if (mvalid) begin
      chk("ch_on", ch_on, m_on_vec());
      chk("ch_rdy", ch_rdy, m_rdy_vec());
`ifdef CLK_GATE_STATS_EN
      for (int c = 0; c < N; c++) chk("gated_cnt", gated_cnt[c*CW +: CW], m_cnt[c]);
`endif
    end
    if (pv) chk("g_clk_hi_early", g_clk, pre_on);
    #3;
    if (pv) chk("g_clk_hi_late", g_clk, pre_on);
  end

  always @(negedge clk) begin
    #1;
    if (mvalid) chk("g_clk_lo", g_clk, '0);
  end

  initial begin
    int offs[5] = '{7, 6, 6, 3, 7};
    // reset held for two edges with all enables high
    repeat (2) begin
      @(negedge clk);
      chk("rst_on", ch_on, 4'h0);
      chk("rst_rdy", ch_rdy, 4'h0);
    end
    rst = 0; ch_en = 4'b0001;
    @(negedge clk);
    chk("wake_on0", ch_on[0], 1'b1);
    chk("wake_rdy0", ch_rdy[0], 1'b0);
    @(posedge clk); #1;
    chk("first_pulse0", g_clk[0], 1'b1);
    chk("rdy0_e1", ch_rdy[0], 1'b0);
    @(posedge clk); #1;
    chk("rdy0_e2", ch_rdy[0], 1'b1);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("idle15_rdy", ch_rdy[0], 1'b1);
    @(negedge clk);
    chk("idle16_rdy", ch_rdy[0], 1'b0);
    chk("idle16_on", ch_on[0], 1'b0);
    @(posedge clk); #1;
    chk("gated_no_pulse", g_clk[0], 1'b0);
    @(negedge clk) ch_busy[0] = 1;
    @(negedge clk) ch_busy[0] = 0;
    chk("rewake_on", ch_on[0], 1'b1);
    @(posedge clk); #1;
    chk("rewake_pulse", g_clk[0], 1'b1);
    @(negedge clk);
    chk("rewake_rdy_early", ch_rdy[0], 1'b0);
    @(negedge clk);
    chk("rewake_rdy", ch_rdy[0], 1'b1);
    // mid-cycle enable toggles on channel 1
    ch_en[1] = 1; ch_busy[1] = 1;
    foreach (offs[k]) begin
      @(posedge clk);
      #(offs[k]) ch_en[1] = ~ch_en[1];
    end
    @(negedge clk);
    ch_en = 4'b0100; ch_busy = '0;
    repeat (20) @(negedge clk);
    chk("ch2_gated", ch_on[2], 1'b0);
    ch_en[2] = 0; ch_busy[2] = 1;
    @(negedge clk);
    chk("ch2_off_on", ch_on[2], 1'b0);
    chk("ch2_off_rdy", ch_rdy[2], 1'b0);
    @(posedge clk); #1;
    chk("ch2_no_pulse", g_clk[2], 1'b0);
    @(negedge clk);
    repeat (400) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        ch_en[c] = $urandom_range(0, 15) != 0;
        ch_busy[c] = $urandom_range(0, 11) == 0;
      end
      stats_clr = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 99) == 0;
    end
    @(negedge clk);
    rst = 0; stats_clr = 0; ch_en = '1; ch_busy = '1;
    repeat (5) @(negedge clk);
    chk("all_run", ch_rdy, 4'hF);
    rst = 1;
    @(negedge clk);
    chk("midrst_on", ch_on, 4'h0);
    chk("midrst_rdy", ch_rdy, 4'h0);
`ifdef CLK_GATE_STATS_EN
    chk("midrst_cnt", gated_cnt, '0);
`endif
    rst = 0; ch_en = '0; ch_busy = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
`ifdef CLK_GATE_STATS_EN
      chk("cnt_step", gated_cnt[CW-1:0], k);
`endif
      chk("off_on", ch_on, 4'h0);
    end
    stats_clr = 1;
    @(negedge clk);
    stats_clr = 0;
`ifdef CLK_GATE_STATS_EN
    chk("cnt_clr", gated_cnt, '0);
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
